spm_write_ctrl: RTL and testbench
=================================

SPM_WRITE_CTRL -- requirements
Module: spm_write_ctrl

Interface
REQ-001 SHALL have parameters: BANK_SIZE, default 512, SRAM depth in words; DBUS_WIDTH, default 32, bridge data width; FIFO_WIDTH, default 36, ingress FIFO entry width; PKT_ID_WIDTH, default 4, packet-ID tag width.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 dbus_in  input  DBUS_WIDTH  word from bridge/ARB.
REQ-005 dbus_in_valid  input  1  dbus_in valid.
REQ-006 dbus_ready  output  1  block accepts dbus_in this cycle.
REQ-007 num_words  input  $clog2(BANK_SIZE)  CSR: payload words per load.
REQ-008 load_busy  output  1  high in any state other than IDLE.
REQ-009 load_fin  output  1  one-cycle pulse at load completion.
REQ-010 enqueue  output  1  push fifo_wdata into ingress FIFO.
REQ-011 fifo_full  input  1  ingress FIFO full.
REQ-012 fifo_wdata  output  FIFO_WIDTH  {pkt_id, data}; pkt_id in [35:32], data in [31:0].

Function
REQ-013 SHALL implement FSM with states IDLE, HDR, LOAD, STREAM, FIN.
REQ-014 IDLE: dbus_ready=0; go to HDR the next cycle.
REQ-015 HDR: dbus_ready=1; on a dbus handshake, latch num_words into the load counter and go to LOAD.
REQ-016 LOAD: dbus_ready=1; each handshake writes dbus_in to SRAM address wr_addr, increments wr_addr and decrements the counter; after the handshake that moves the counter from 1 to 0, go to STREAM.
REQ-017 The latched value num_words=0 SHALL mean BANK_SIZE words; the counter wraps and the FSM stops when it next reaches 0.
REQ-018 STREAM: dbus_ready=0; SRAM reads issue from rd_addr=0 upward; each read result (1-cycle SRAM latency) enters a 2-entry output buffer.
REQ-019 A read SHALL issue only when buffer occupancy + reads in flight < 2, so the buffer never overflows.
REQ-020 enqueue SHALL be 1 when the buffer is non-empty and fifo_full=0; the buffer pops on the same cycle.
REQ-021 fifo_wdata SHALL equal {pkt_id, head data}; pkt_id starts at 0 per load, increments per enqueue, and wraps mod 2^PKT_ID_WIDTH.
REQ-022 STREAM exits to FIN in the cycle after the final word (count = latched length) is enqueued.
REQ-023 FIN: load_fin=1 for exactly one cycle, then go to IDLE.
REQ-024 dbus_in_valid while dbus_ready=0 SHALL be ignored; no write occurs.
REQ-025 fifo_full=1 SHALL stall enqueue indefinitely with fifo_wdata held stable; no data is lost or duplicated.
REQ-026 num_words changes after HDR SHALL NOT affect an in-progress load.

Reset
REQ-027 rst in any state SHALL return the FSM to IDLE; dbus_ready, enqueue, load_fin and load_busy are 0 the following cycle.
REQ-028 Reset SHALL clear wr_addr, rd_addr, pkt_id, the counters and the output buffer; SRAM contents are not cleared.

Configuration
REQ-029 SHALL support macro SPM_MAGIC_CHECK_EN.
REQ-030 With SPM_MAGIC_CHECK_EN defined: in HDR, a handshake whose dbus_in is not 32'hECEBCAFE SHALL be consumed and dropped, with the FSM staying in HDR; a MAGIC word moves the FSM to LOAD and is not stored.
REQ-031 Without SPM_MAGIC_CHECK_EN: the HDR handshake word is not inspected, is dropped as the header, and the FSM moves to LOAD.

Structure
REQ-032 The FSM state enum spm_sram_write_fsm_t and the MAGIC constant SHALL live in package spm_types.
REQ-033 The SRAM SHALL be the existing spm_sram_wrapper, connected through scratchpad_bank_if.
REQ-034 The 2-entry output buffer SHALL be a sub-module spm_wr_skid, parameterised by FIFO_WIDTH.

Verification
REQ-035 num_words=4 -> stimulus: MAGIC, then A0..A3 back-to-back, fifo_full=0 -> response: enqueue data A0..A3 with pkt_id 0..3, then load_fin one cycle after the last enqueue.
REQ-036 SPM_MAGIC_CHECK_EN defined -> stimulus: 0x1234, then MAGIC, then 2 words with num_words=2 -> response: 0x1234 dropped, exactly 2 enqueues.
REQ-037 num_words=20 -> response: pkt_id sequence 0..15, 0..3 (wrap at 16); data matches input order.
REQ-038 fifo_full toggled with a random 50% duty during STREAM of 8 words -> response: 8 enqueues, in order, no duplicates, fifo_wdata stable while stalled.
REQ-039 rst asserted mid-LOAD after 3 of 8 words -> response: IDLE next cycle, no enqueue; a fresh load of 2 words then completes with pkt_id 0,1.
REQ-040 num_words=0 -> response: 512 words accepted and 512 enqueued; a dbus_in_valid pulse during STREAM is ignored.

Source files
------------

// File: rtl/spm_types.sv
// -----------------------------------------------------------------------------
// spm_types
// Shared types and constants for the scratchpad write controller.
//   spm_sram_write_fsm_t : load/stream FSM state encoding
//   SPM_MAGIC            : header word accepted when header checking is built in
// -----------------------------------------------------------------------------
package spm_types;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR    = 3'd1,
      LOAD   = 3'd2,
      STREAM = 3'd3,
      FIN    = 3'd4
   } spm_sram_write_fsm_t;

   localparam logic [31:0] SPM_MAGIC = 32'hECEB_CAFE;

endpackage

// File: rtl/scratchpad_bank_if.sv
// -----------------------------------------------------------------------------
// scratchpad_bank_if
// Single-port-write / single-port-read bank interface between the write
// controller and the SRAM wrapper.
//   we/waddr/wdata : write strobe, address, data
//   re/raddr       : read strobe and address
//   rdata          : read data, valid one cycle after re
// Modports: ctrl (controller side), mem (memory side).
// -----------------------------------------------------------------------------
interface scratchpad_bank_if #(
   parameter int AW = 9,
   parameter int DW = 32
) ();
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          re;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;

   modport ctrl (output we, waddr, wdata, re, raddr, input rdata);
   modport mem  (input we, waddr, wdata, re, raddr, output rdata);
endinterface

// File: rtl/spm_sram_wrapper.sv
// -----------------------------------------------------------------------------
// spm_sram_wrapper
// Behavioural scratchpad SRAM bank, one write and one read port, 1-cycle read
// latency. Contents are never reset.
//   clk  : clock
//   bank : scratchpad_bank_if.mem
// -----------------------------------------------------------------------------
module spm_sram_wrapper #(
   parameter int DEPTH = 512,
   parameter int DW    = 32
) (
   input logic             clk,
   scratchpad_bank_if.mem  bank
);
   logic [DW-1:0] mem_r [DEPTH];
   logic [DW-1:0] rdata_r;

   // Memory array write and registered read.
   always_ff @(posedge clk) begin
      if (bank.we) begin
         mem_r[bank.waddr] <= bank.wdata;
      end
      if (bank.re) begin
         rdata_r <= mem_r[bank.raddr];
      end
   end

   assign bank.rdata = rdata_r;
endmodule

// File: rtl/spm_wr_skid.sv
// -----------------------------------------------------------------------------
// spm_wr_skid
// Two-entry in-order output buffer. Push and pop may occur in the same cycle.
// The head entry never changes while it is not popped.
//   clk, rst   : clock, synchronous active-high reset
//   push/data  : write an entry (caller guarantees no overflow)
//   pop        : remove head (caller guarantees non-empty)
//   head       : oldest entry
//   count      : occupancy 0..2
// -----------------------------------------------------------------------------
module spm_wr_skid #(
   parameter int FIFO_WIDTH = 36
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [FIFO_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [FIFO_WIDTH-1:0] head,
   output logic [1:0]            count
);
   logic [FIFO_WIDTH-1:0] ent0_r;
   logic [FIFO_WIDTH-1:0] ent1_r;
   logic [1:0]            cnt_r;

   // Entry storage and occupancy tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent0_r <= {FIFO_WIDTH{1'b0}};
         ent1_r <= {FIFO_WIDTH{1'b0}};
         cnt_r  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_r == 2'd0) begin
                  ent0_r <= push_data;
               end else begin
                  ent1_r <= push_data;
               end
               cnt_r <= cnt_r + 2'd1;
            end
            2'b01: begin
               ent0_r <= ent1_r;
               cnt_r  <= cnt_r - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; new word lands behind the survivor.
               if (cnt_r == 2'd1) begin
                  ent0_r <= push_data;
               end else begin
                  ent0_r <= ent1_r;
                  ent1_r <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head  = ent0_r;
   assign count = cnt_r;
endmodule

// File: rtl/spm_write_ctrl.sv
// -----------------------------------------------------------------------------
// spm_write_ctrl
// Loads a packet from the bridge data bus into a scratchpad bank, then streams
// it back out into the ingress FIFO tagged with a wrapping packet ID.
// Sequence: IDLE -> HDR (header word) -> LOAD (num_words payload words; 0 means
// BANK_SIZE) -> STREAM (read back, enqueue) -> FIN (one-cycle load_fin).
// Build option: SPM_MAGIC_CHECK_EN -- when defined, header words other than
// SPM_MAGIC are consumed and dropped while waiting in HDR.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   dbus_in/_valid, dbus_ready: bridge word input with handshake
//   num_words                 : payload length CSR, latched at the header
//   load_busy, load_fin       : status (busy outside IDLE, completion pulse)
//   enqueue, fifo_full        : ingress FIFO push / backpressure
//   fifo_wdata                : {pkt_id, data}
// -----------------------------------------------------------------------------
module spm_write_ctrl
   import spm_types::*;
#(
   parameter int BANK_SIZE    = 512,
   parameter int DBUS_WIDTH   = 32,
   parameter int FIFO_WIDTH   = 36,
   parameter int PKT_ID_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DBUS_WIDTH-1:0]        dbus_in,
   input  logic                         dbus_in_valid,
   output logic                         dbus_ready,
   input  logic [$clog2(BANK_SIZE)-1:0] num_words,
   output logic                         load_busy,
   output logic                         load_fin,
   output logic                         enqueue,
   input  logic                         fifo_full,
   output logic [FIFO_WIDTH-1:0]        fifo_wdata
);
   localparam int AW = $clog2(BANK_SIZE);

   spm_sram_write_fsm_t     state_r;
   spm_sram_write_fsm_t     state_s;
   logic                    ready_s;
   logic                    hs_s;
   logic                    hdr_ok_s;
   logic                    rd_issue_s;
   logic                    enq_s;
   logic [AW:0]             len_s;
   logic [AW-1:0]           cnt_r;
   logic [AW-1:0]           wr_addr_r;
   logic [AW:0]             len_r;
   logic [AW:0]             rd_cnt_r;
   logic [AW:0]             enq_cnt_r;
   logic [PKT_ID_WIDTH-1:0] pkt_id_r;
   logic                    rd_valid_r;
   logic [1:0]              occ_s;
   logic [FIFO_WIDTH-1:0]   head_s;

   scratchpad_bank_if #(.AW(AW), .DW(DBUS_WIDTH)) bank_if ();

   spm_sram_wrapper #(.DEPTH(BANK_SIZE), .DW(DBUS_WIDTH)) u_sram (
      .clk  (clk),
      .bank (bank_if)
   );

   // Tag is attached when a word enters the buffer; order is preserved, so it
   // equals the per-enqueue count.
   spm_wr_skid #(.FIFO_WIDTH(FIFO_WIDTH)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_valid_r),
      .push_data ({pkt_id_r, bank_if.rdata}),
      .pop       (enq_s),
      .head      (head_s),
      .count     (occ_s)
   );

   // Handshake, read-issue and enqueue qualifiers.
   always_comb begin
      ready_s = (state_r == HDR) || (state_r == LOAD);
      hs_s    = ready_s && dbus_in_valid;
`ifdef SPM_MAGIC_CHECK_EN
      hdr_ok_s = (dbus_in == SPM_MAGIC);
`else
      hdr_ok_s = 1'b1;
`endif
      // A zero length means a full bank.
      if (num_words == {AW{1'b0}}) begin
         len_s = (AW+1)'(BANK_SIZE);
      end else begin
         len_s = {1'b0, num_words};
      end
      // Never issue a read that could find the buffer full when it returns.
      rd_issue_s = (state_r == STREAM) && (rd_cnt_r < len_r) &&
                   (({1'b0, occ_s} + {2'b00, rd_valid_r}) < 3'd2);
      enq_s      = (state_r == STREAM) && (occ_s != 2'd0) && !fifo_full;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: state_s = HDR;
         HDR: begin
            if (hs_s && hdr_ok_s) begin
               state_s = LOAD;
            end else begin
               state_s = HDR;
            end
         end
         LOAD: begin
            if (hs_s && (cnt_r == {{(AW-1){1'b0}}, 1'b1})) begin
               state_s = STREAM;
            end else begin
               state_s = LOAD;
            end
         end
         STREAM: begin
            if (enq_s && (enq_cnt_r == (len_r - {{AW{1'b0}}, 1'b1}))) begin
               state_s = FIN;
            end else begin
               state_s = STREAM;
            end
         end
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Load/stream datapath: addresses, counters and packet tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r      <= {AW{1'b0}};
         wr_addr_r  <= {AW{1'b0}};
         len_r      <= {(AW+1){1'b0}};
         rd_cnt_r   <= {(AW+1){1'b0}};
         enq_cnt_r  <= {(AW+1){1'b0}};
         pkt_id_r   <= {PKT_ID_WIDTH{1'b0}};
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_issue_s;
         case (state_r)
            IDLE: begin
               cnt_r     <= {AW{1'b0}};
               wr_addr_r <= {AW{1'b0}};
               rd_cnt_r  <= {(AW+1){1'b0}};
               enq_cnt_r <= {(AW+1){1'b0}};
               pkt_id_r  <= {PKT_ID_WIDTH{1'b0}};
            end
            HDR: begin
               if (hs_s && hdr_ok_s) begin
                  cnt_r <= num_words;
                  len_r <= len_s;
               end
            end
            LOAD: begin
               if (hs_s) begin
                  wr_addr_r <= wr_addr_r + {{(AW-1){1'b0}}, 1'b1};
                  cnt_r     <= cnt_r - {{(AW-1){1'b0}}, 1'b1};
               end
            end
            STREAM: begin
               if (rd_issue_s) begin
                  rd_cnt_r <= rd_cnt_r + {{AW{1'b0}}, 1'b1};
               end
               if (rd_valid_r) begin
                  pkt_id_r <= pkt_id_r + {{(PKT_ID_WIDTH-1){1'b0}}, 1'b1};
               end
               if (enq_s) begin
                  enq_cnt_r <= enq_cnt_r + {{AW{1'b0}}, 1'b1};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bank_if.we    = hs_s && (state_r == LOAD);
   assign bank_if.waddr = wr_addr_r;
   assign bank_if.wdata = dbus_in;
   assign bank_if.re    = rd_issue_s;
   assign bank_if.raddr = rd_cnt_r[AW-1:0];

   assign dbus_ready = ready_s;
   assign load_busy  = (state_r != IDLE);
   assign load_fin   = (state_r == FIN);
   assign enqueue    = enq_s;
   assign fifo_wdata = head_s;
endmodule

// File: tb/tb_spm_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spm_write_ctrl
// Directed self-checking bench for spm_write_ctrl with hand-computed expected
// {pkt_id, data} sequences. Header-filter case runs only when the design is
// built with SPM_MAGIC_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_spm_write_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dbus_in;
   logic        dbus_in_valid;
   logic        dbus_ready;
   logic [8:0]  num_words;
   logic        load_busy;
   logic        load_fin;
   logic        enqueue;
   logic        fifo_full;
   logic [35:0] fifo_wdata;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_enq_cyc = 0;
   logic [35:0] exp_q[$];
   logic [35:0] got_q[$];
   bit          seen_head = 1'b0;

   spm_write_ctrl #(
      .BANK_SIZE(512), .DBUS_WIDTH(32), .FIFO_WIDTH(36), .PKT_ID_WIDTH(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .dbus_in       (dbus_in),
      .dbus_in_valid (dbus_in_valid),
      .dbus_ready    (dbus_ready),
      .num_words     (num_words),
      .load_busy     (load_busy),
      .load_fin      (load_fin),
      .enqueue       (enqueue),
      .fifo_full     (fifo_full),
      .fifo_wdata    (fifo_wdata)
   );

   always #5 clk = ~clk;

   // Cycle counter for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Capture enqueues; once the expected next word is visible under stall it
   // must stay put until popped.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (enqueue === 1'b1) begin
            got_q.push_back(fifo_wdata);
            last_enq_cyc = cyc;
            seen_head    = 1'b0;
         end else if (got_q.size() < exp_q.size()) begin
            if (seen_head) begin
               chk("stall_hold", 64'(fifo_wdata), 64'(exp_q[got_q.size()]));
            end else if (fifo_full === 1'b1 && fifo_wdata === exp_q[got_q.size()]) begin
               seen_head = 1'b1;
            end
         end
      end
   end

   task automatic wait_hdr();
      int k;
      k = 0;
      while (dbus_ready !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("hdr_ready", 64'(dbus_ready), 64'd1);
   endtask

   task automatic run_load(input int nw, input int n, input logic [31:0] base,
                           input bit rf, input bit stray, input bit bad_hdr);
      int k;
      exp_q.delete();
      got_q.delete();
      seen_head = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({4'(i % 16), base + 32'(i)});
      end
      num_words = 9'(nw);
      wait_hdr();
      if (bad_hdr) begin
         dbus_in = 32'h0000_1234; dbus_in_valid = 1'b1;
         @(posedge clk); #1;
      end
      dbus_in = 32'hECEB_CAFE; dbus_in_valid = 1'b1;
      @(posedge clk); #1;
      num_words = 9'(nw + 3);   // late CSR change must not matter
      chk("load_busy", 64'(load_busy), 64'd1);
      for (int i = 0; i < n; i++) begin
         dbus_in = base + 32'(i);
         @(posedge clk); #1;
      end
      dbus_in_valid = 1'b0;
      chk("stream_ready", 64'(dbus_ready), 64'd0);
      if (stray) begin
         dbus_in = 32'hDEAD_BEEF; dbus_in_valid = 1'b1;
         @(posedge clk); #1;
         dbus_in_valid = 1'b0;
      end
      k = 0;
      while (k < 4000) begin
         if (load_fin === 1'b1) break;
         fifo_full = rf ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         k++;
      end
      fifo_full = 1'b0;
      chk("fin_seen", 64'(load_fin), 64'd1);
      chk("fin_gap", 64'(cyc - last_enq_cyc), 64'd1);
      @(posedge clk); #1;
      chk("fin_pulse", 64'(load_fin), 64'd0);
      chk("idle_busy", 64'(load_busy), 64'd0);
      chk("enq_count", 64'(got_q.size()), 64'(n));
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         chk($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      end
   endtask

   initial begin
      rst = 1'b1; dbus_in = 32'd0; dbus_in_valid = 1'b0;
      num_words = 9'd4; fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(dbus_ready), 64'd0);
      chk("rst_busy", 64'(load_busy), 64'd0);
      chk("rst_fin", 64'(load_fin), 64'd0);
      chk("rst_enq", 64'(enqueue), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("hdr_after_rst", 64'(dbus_ready), 64'd1);

      run_load(4, 4, 32'h0000_00A0, 1'b0, 1'b0, 1'b0);
      run_load(20, 20, 32'h1000_0000, 1'b0, 1'b0, 1'b0);
      run_load(8, 8, 32'h2000_0000, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a load.
      exp_q.delete();
      got_q.delete();
      num_words = 9'd8;
      wait_hdr();
      dbus_in = 32'hECEB_CAFE; dbus_in_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         dbus_in = 32'hBAD0_0000 + 32'(i);
         @(posedge clk); #1;
      end
      dbus_in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_ready", 64'(dbus_ready), 64'd0);
      chk("mid_rst_busy", 64'(load_busy), 64'd0);
      chk("mid_rst_fin", 64'(load_fin), 64'd0);
      chk("mid_rst_enq", 64'(enqueue), 64'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("no_enq_after_rst", 64'(got_q.size()), 64'd0);
      run_load(2, 2, 32'h5500_0000, 1'b0, 1'b0, 1'b0);

`ifdef SPM_MAGIC_CHECK_EN
      run_load(2, 2, 32'h6600_0000, 1'b0, 1'b0, 1'b1);
`endif

      run_load(0, 512, 32'h7000_0000, 1'b0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
